// File: rtl/pla_harness_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pla_harness_pkg : shared constants and state encoding for PLA harness ctrls
// Revision: 1.0
// ---------------------------------------------------------------------------
package pla_harness_pkg;

  localparam int SETTLE_W = 4;
  localparam int DEF_N_IN = 10;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pla_settle_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pla_settle_timer : loadable down-counter that stops at zero, with zero flag
// Revision: 1.0
// ---------------------------------------------------------------------------
module pla_settle_timer
  import pla_harness_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/pla_sweep_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pla_sweep_ctrl : walks a single-output PLA through every input vector,
//                  counts onset minterms and streams per-vector results
// Revision: 1.0
// ---------------------------------------------------------------------------
module pla_sweep_ctrl
  import pla_harness_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = 1,
  parameter int CNT_W  = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             onset_only,
  output logic [N_IN-1:0]  vec_o,
  input  logic             y_i,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] onset_cnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N_IN-1:0]  res_vec,
  output logic             res_y
);

  localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(SETTLE - 1);

  state_t state;
  logic   only_q;
  logic   tmr_zero;
  logic   tmr_load;
  logic   tmr_en;
  logic   sample;
  logic   emit_next;
  logic   handshake;
  logic   advance;

  // abort suppresses sampling and handshakes so a cancelled result is dropped
  assign sample    = (state == ST_WAIT) && tmr_zero && !abort;
  assign emit_next = !only_q || y_i;
  assign handshake = (state == ST_EMIT) && res_ready && !abort;
  assign advance   = (sample && !emit_next && !(&vec_o)) ||
                     (handshake && !(&res_vec));

  assign tmr_load = ((state == ST_IDLE) && start) || advance;
  assign tmr_en   = (state == ST_WAIT);

  pla_settle_timer #(
    .W (SETTLE_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (RELOAD),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vec_o     <= '0;
      onset_cnt <= '0;
      res_vec   <= '0;
      res_y     <= 1'b0;
      only_q    <= 1'b0;
    end else begin
      if (advance) begin
        vec_o <= vec_o + N_IN'(1);
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_WAIT;
            vec_o     <= '0;
            onset_cnt <= '0;
            only_q    <= onset_only;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (sample) begin
            res_y   <= y_i;
            res_vec <= vec_o;
            if (y_i) begin
              onset_cnt <= onset_cnt + CNT_W'(1);
            end
            if (emit_next) begin
              state <= ST_EMIT;
            end else if (&vec_o) begin
              state <= ST_DONE;
            end
          end
        end
        ST_EMIT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (handshake) begin
            state <= (&res_vec) ? ST_DONE : ST_WAIT;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign res_valid = (state == ST_EMIT);

endmodule
`default_nettype wire

// File: doc/pla_sweep_ctrl.md
Name: pla_sweep_ctrl

Overview:
- Sequencer that exhaustively drives a combinational single-output PLA block (N_IN inputs, one output) through all 2^N_IN input vectors.
- Samples the block output after a fixed settle delay, counts onset minterms, and streams per-vector results over a valid/ready interface.
- Sits beside each PLA netlist in the benchmark harness, so every optimised netlist is characterised in hardware by the same controller.

Parameters:
- N_IN, 10, width of the PLA input vector.
- SETTLE, 1, cycles between driving vec_o and sampling y_i; legal range 1..15.
- CNT_W, N_IN+1, onset counter width; holds 2^N_IN without overflow.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep; ignored unless idle.
- abort  in  1  synchronous cancel of a running sweep.
- onset_only  in  1  sampled at start; 1 = emit results only for vectors with y=1.
- vec_o  out  N_IN  input vector driven to the PLA.
- y_i  in  1  PLA output.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse when a sweep completes; not asserted on abort.
- onset_cnt  out  CNT_W  number of vectors with y_i=1 in the current or last sweep.
- res_valid  out  1  result stream valid.
- res_ready  in  1  result stream ready.
- res_vec  out  N_IN  vector for the current result.
- res_y  out  1  sampled PLA output for res_vec.

Behaviour:
- Reset (async, rst_n=0): state IDLE; vec_o=0, onset_cnt=0, busy=0, done=0, res_valid=0, res_vec=0, res_y=0, settle counter=0, latched onset_only=0.
- States: IDLE, WAIT, EMIT, DONE.
- IDLE: start=1 sets vec_o=0, clears onset_cnt, latches onset_only, loads settle counter with SETTLE-1, and goes to WAIT. busy rises at the same edge.
- WAIT: the settle counter decrements each cycle. On the edge where it equals 0:
  - y_i is captured into res_y and vec_o is copied to res_vec.
  - onset_cnt increments if y_i=1.
  - If emitting (latched onset_only=0, or y_i=1): go to EMIT.
  - Otherwise, if vec_o is all ones, go to DONE; else vec_o increments, the counter reloads, and the state stays WAIT.
- EMIT: res_valid=1. res_vec and res_y are held stable while res_ready=0.
  - On the valid&ready edge, res_valid falls.
  - If res_vec is all ones, go to DONE; else vec_o increments, the counter reloads, and the state goes to WAIT.
- DONE: done=1 for exactly one cycle, busy=0 on the following edge, then IDLE. onset_cnt holds until the next start.
- vec_o changes only on an advance edge and is stable for at least SETTLE full cycles before y_i is sampled.
- Throughput with res_ready held at 1:
  - SETTLE+1 cycles per emitted vector.
  - SETTLE cycles per filtered (suppressed) vector.
  - Full unfiltered sweep with SETTLE=1: 2048 cycles from start to done.
- Wrap-around: vec_o never wraps. The all-ones vector is the final one, and there is no increment after it.
- abort=1 in WAIT, EMIT or DONE: next edge goes to IDLE with busy=0, done=0, res_valid=0. vec_o and onset_cnt keep their partial values. abort has priority over every other transition, including a valid&ready handshake in the same cycle (the result counts as dropped).
- start while busy: ignored. start and abort together in IDLE: start wins, since abort has no effect in IDLE.
- res_valid never drops without a handshake, except on abort or reset.
- Reset mid-sweep: all outputs return to their reset values immediately (asynchronous).

Decomposition:
- Shared package pla_harness_pkg holds:
  - the state enum (IDLE, WAIT, EMIT, DONE);
  - the SETTLE counter width constant (4);
  - the default N_IN.
- One sub-module, pla_settle_timer: a loadable down-counter with a zero flag, reused by the other harness controllers.
- Everything else stays in pla_sweep_ctrl.

Test Plan:
- Bench PLA y = (x0|x1|x2|x3) & ~(x4|x5|x6|x7), with x8 and x9 unused. N_IN=10, SETTLE=1, onset_only=0, res_ready=1, pulse start -> 1024 results in ascending order, onset_cnt=60, done exactly 2048 cycles after start, busy low the cycle after done.
- Same PLA with onset_only=1 -> exactly 60 results, all with res_y=1. The first has res_vec=0x001, the last has res_vec=0x30F. onset_cnt=60.
- Backpressure: res_ready toggles with a 1-in-3 duty cycle -> res_vec and res_y stable while valid&~ready, no result lost or duplicated, onset_cnt=60.
- SETTLE=3: PLA output modelled with a 2-cycle delay -> sampled values match the ideal function, with 4 cycles per vector.
- abort asserted in EMIT at vector 0x055 together with res_ready=1 -> IDLE next cycle, no done pulse, onset_cnt holds its partial value. A new start then restarts from 0 and gives onset_cnt=60.
- rst_n pulsed low mid-WAIT at vector 0x200 -> all outputs 0 immediately, and start is accepted after rst_n rises.
